dense_parallel_mac: RTL and testbench

//  Fully-connected layer engine, successor to the single-lane dense block. Computes

---
 rtl/dense_parallel_mac.sv | 168 ++++++++++++++++
 tb/tb_dense_parallel_mac.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_parallel_mac.sv
// Dense layer engine: computes LANES neurons per pass over the input buffer,
// with saturating fixed-point results, optional ReLU and a running argmax.
module dense_parallel_mac #(
  parameter int IN_COUNT         = 1600,
  parameter int OUT_COUNT        = 10,
  parameter int DATA_SIZE        = 32,
  parameter int FRAC_BITS        = 16,
  parameter int ACC_SIZE         = 64,
  parameter int LANES            = 2,
  parameter int RELU_EN          = 0,
  parameter int WEIGHT_ADR_WIDTH = 14,
  parameter int BIAS_ADR_WIDTH   = 4,
  parameter int IN_ADR_WIDTH     = 11,
  parameter int OUT_ADR_WIDTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [WEIGHT_ADR_WIDTH-1:0]   weightAdr,
  input  logic [LANES*DATA_SIZE-1:0]    weightData,
  output logic [BIAS_ADR_WIDTH-1:0]     biasAdr,
  input  logic [LANES*DATA_SIZE-1:0]    biasData,
  input  logic                          axisif_start,
  output logic                          axisif_done,
  output logic [IN_ADR_WIDTH-1:0]       axisif_bufferIn_adr,
  input  logic signed [DATA_SIZE-1:0]   axisif_bufferIn_data,
  output logic [OUT_ADR_WIDTH-1:0]      axisif_bufferOut_adr,
  output logic [DATA_SIZE-1:0]          axisif_bufferOut_data,
  output logic                          axisif_bufferOut_wr,
  output logic [OUT_ADR_WIDTH-1:0]      argmax
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IN_ADR_WIDTH-1:0]  LAST_IN   = IN_ADR_WIDTH'(IN_COUNT - 1);
  localparam logic [OUT_ADR_WIDTH-1:0] LAST_OUT  = OUT_ADR_WIDTH'(OUT_COUNT - 1);
  localparam logic [LANE_W-1:0]        LAST_LANE = LANE_W'(LANES - 1);
  localparam logic signed [ACC_SIZE-1:0] MAX_VAL =
    {{(ACC_SIZE-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] MIN_VAL =
    {{(ACC_SIZE-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, BIAS, MAC, LAST, WRITE, DONE} stateT;

  stateT stateReg, stateNext;
  logic [BIAS_ADR_WIDTH-1:0]   groupReg;
  logic [LANE_W-1:0]           laneReg;
  logic [IN_ADR_WIDTH-1:0]     inAdrReg;
  logic [WEIGHT_ADR_WIDTH-1:0] weightAdrReg;
  logic [OUT_ADR_WIDTH-1:0]    outAdrHold;
  logic [DATA_SIZE-1:0]        outDataHold;
  logic [OUT_ADR_WIDTH-1:0]    argmaxReg;
  logic signed [DATA_SIZE-1:0] bestReg;
  logic [OUT_ADR_WIDTH-1:0]    neuronIdx;
  logic [LANES*ACC_SIZE-1:0]   accAll;
  logic signed [ACC_SIZE-1:0]  accSel;
  logic signed [ACC_SIZE-1:0]  shifted;
  logic signed [DATA_SIZE-1:0] result;

  assign neuronIdx = OUT_ADR_WIDTH'(int'(groupReg) * LANES + int'(laneReg));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:  if (axisif_start) stateNext = BIAS;
      BIAS:  stateNext = MAC;
      MAC:   if (inAdrReg == LAST_IN) stateNext = LAST;
      LAST:  stateNext = WRITE;
      WRITE: begin
        // Tail group stops at the last real neuron instead of the last lane.
        if (neuronIdx == LAST_OUT)       stateNext = DONE;
        else if (laneReg == LAST_LANE)   stateNext = BIAS;
      end
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Weight words are consecutive across groups, so the address just keeps counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      groupReg     <= '0;
      laneReg      <= '0;
      inAdrReg     <= '0;
      weightAdrReg <= '0;
      outAdrHold   <= '0;
      outDataHold  <= '0;
      argmaxReg    <= '0;
      bestReg      <= '0;
    end else begin
      case (stateReg)
        IDLE: if (axisif_start) begin
          groupReg  <= '0;
          argmaxReg <= '0;
          bestReg   <= '0;
        end
        BIAS: begin
          inAdrReg     <= '0;
          weightAdrReg <= (groupReg == '0) ? '0 : weightAdrReg + WEIGHT_ADR_WIDTH'(1);
        end
        MAC: if (inAdrReg != LAST_IN) begin
          inAdrReg     <= inAdrReg + IN_ADR_WIDTH'(1);
          weightAdrReg <= weightAdrReg + WEIGHT_ADR_WIDTH'(1);
        end
        LAST: laneReg <= '0;
        WRITE: begin
          outAdrHold  <= neuronIdx;
          outDataHold <= result;
          if (neuronIdx == '0 || result > bestReg) begin
            bestReg   <= result;
            argmaxReg <= neuronIdx;
          end
          laneReg <= laneReg + LANE_W'(1);
          if (laneReg == LAST_LANE && neuronIdx != LAST_OUT)
            groupReg <= groupReg + BIAS_ADR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Data for the address issued in MAC cycle k arrives in cycle k+1, hence LAST.
  genvar gi;
  for (gi = 0; gi < LANES; gi++) begin : genLane
    logic signed [DATA_SIZE-1:0]   laneWeight;
    logic signed [DATA_SIZE-1:0]   laneBias;
    logic signed [2*DATA_SIZE-1:0] laneProd;
    logic signed [ACC_SIZE-1:0]    laneAcc;

    assign laneWeight = weightData[gi*DATA_SIZE +: DATA_SIZE];
    assign laneBias   = biasData[gi*DATA_SIZE +: DATA_SIZE];
    assign laneProd   = (2*DATA_SIZE)'(laneWeight) * (2*DATA_SIZE)'(axisif_bufferIn_data);

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        laneAcc <= '0;
      else if (stateReg == MAC && inAdrReg == '0)
        laneAcc <= ACC_SIZE'(laneBias) <<< FRAC_BITS;
      else if (stateReg == MAC || stateReg == LAST)
        laneAcc <= laneAcc + ACC_SIZE'(laneProd);
    end

    assign accAll[gi*ACC_SIZE +: ACC_SIZE] = laneAcc;
  end

  assign accSel = accAll[int'(laneReg)*ACC_SIZE +: ACC_SIZE];

  always_comb begin
    shifted = accSel >>> FRAC_BITS;
    if (shifted > MAX_VAL)      result = DATA_SIZE'(MAX_VAL);
    else if (shifted < MIN_VAL) result = DATA_SIZE'(MIN_VAL);
    else                        result = DATA_SIZE'(shifted);
    if (RELU_EN != 0 && result[DATA_SIZE-1]) result = '0;
  end

  assign weightAdr             = weightAdrReg;
  assign biasAdr               = groupReg;
  assign axisif_bufferIn_adr   = inAdrReg;
  assign axisif_bufferOut_wr   = (stateReg == WRITE);
  assign axisif_bufferOut_adr  = (stateReg == WRITE) ? neuronIdx : outAdrHold;
  assign axisif_bufferOut_data = (stateReg == WRITE) ? result : outDataHold;
  assign axisif_done           = (stateReg == DONE);
  assign argmax                = argmaxReg;

endmodule

// File: tb/tb_dense_parallel_mac.sv
// Bench for dense_parallel_mac: a plain-arithmetic neuron model plus a table of
// fixed-point vectors, run on a ReLU-off and a ReLU-on instance side by side.
module tb_dense_parallel_mac;
  localparam int IN_N = 4, OUT_N = 3, LANES = 2, DS = 32;
  localparam int WAW = 4, BAW = 2, IAW = 2, OAW = 2, NVEC = 10;

  typedef logic signed [31:0] wordT;
  typedef struct {
    wordT in [IN_N];
    wordT w [OUT_N][IN_N];
    wordT b [OUT_N];
    wordT exp [OUT_N];
    wordT expRelu [OUT_N];
    int   arg;
    int   argRelu;
  } vecT;

  localparam wordT ONE = 32'h0001_0000, HALF = 32'h0000_8000, TWO = 32'h0002_0000;
  localparam wordT K30 = 32'h7530_0000;

  logic clk = 0, rst = 1, start = 0;
  always #5 clk = ~clk;

  logic [LANES*DS-1:0] wMem [16];
  logic [LANES*DS-1:0] bMem [4];
  wordT                inMem [4];

  logic [WAW-1:0] wAdr0, wAdr1;
  logic [BAW-1:0] bAdr0, bAdr1;
  logic [IAW-1:0] iAdr0, iAdr1;
  logic [OAW-1:0] oAdr0, oAdr1, amax0, amax1;
  logic [LANES*DS-1:0] wData0, wData1, bData0, bData1;
  logic signed [DS-1:0] iData0, iData1;
  logic [DS-1:0] oData0, oData1;
  logic wr0, wr1, done0, done1;

  dense_parallel_mac #(.IN_COUNT(IN_N), .OUT_COUNT(OUT_N), .DATA_SIZE(DS), .FRAC_BITS(16),
    .ACC_SIZE(64), .LANES(LANES), .RELU_EN(0), .WEIGHT_ADR_WIDTH(WAW),
    .BIAS_ADR_WIDTH(BAW), .IN_ADR_WIDTH(IAW), .OUT_ADR_WIDTH(OAW)) dut0 (
    .clk(clk), .rst(rst), .weightAdr(wAdr0), .weightData(wData0), .biasAdr(bAdr0),
    .biasData(bData0), .axisif_start(start), .axisif_done(done0),
    .axisif_bufferIn_adr(iAdr0), .axisif_bufferIn_data(iData0),
    .axisif_bufferOut_adr(oAdr0), .axisif_bufferOut_data(oData0),
    .axisif_bufferOut_wr(wr0), .argmax(amax0));

  dense_parallel_mac #(.IN_COUNT(IN_N), .OUT_COUNT(OUT_N), .DATA_SIZE(DS), .FRAC_BITS(16),
    .ACC_SIZE(64), .LANES(LANES), .RELU_EN(1), .WEIGHT_ADR_WIDTH(WAW),
    .BIAS_ADR_WIDTH(BAW), .IN_ADR_WIDTH(IAW), .OUT_ADR_WIDTH(OAW)) dut1 (
    .clk(clk), .rst(rst), .weightAdr(wAdr1), .weightData(wData1), .biasAdr(bAdr1),
    .biasData(bData1), .axisif_start(start), .axisif_done(done1),
    .axisif_bufferIn_adr(iAdr1), .axisif_bufferIn_data(iData1),
    .axisif_bufferOut_adr(oAdr1), .axisif_bufferOut_data(oData1),
    .axisif_bufferOut_wr(wr1), .argmax(amax1));

  // Synchronous-read memories: data follows the address by one cycle.
  always @(posedge clk) begin
    wData0 <= wMem[wAdr0];  wData1 <= wMem[wAdr1];
    bData0 <= bMem[bAdr0];  bData1 <= bMem[bAdr1];
    iData0 <= inMem[iAdr0]; iData1 <= inMem[iAdr1];
  end

  logic [31:0] capAdr [2][8];
  logic [31:0] capData [2][8];
  int capCnt [2];
  int doneCnt [2];

  always @(negedge clk) begin
    if (wr0) begin
      capAdr[0][capCnt[0] & 7]  <= 32'(oAdr0);
      capData[0][capCnt[0] & 7] <= oData0;
      capCnt[0] <= capCnt[0] + 1;
    end
    if (wr1) begin
      capAdr[1][capCnt[1] & 7]  <= 32'(oAdr1);
      capData[1][capCnt[1] & 7] <= oData1;
      capCnt[1] <= capCnt[1] + 1;
    end
    if (done0) doneCnt[0] <= doneCnt[0] + 1;
    if (done1) doneCnt[1] <= doneCnt[1] + 1;
  end

  vecT v [NVEC];
  int nChecks = 0, nFails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference neuron: exact 64-bit sum, floor shift, clamp to 32-bit range.
  function automatic wordT model(input int k, input int n, input bit relu);
    longint acc;
    acc = longint'(v[k].b[n]) <<< 16;
    for (int i = 0; i < IN_N; i++) acc += longint'(v[k].in[i]) * longint'(v[k].w[n][i]);
    acc = acc >>> 16;
    if (acc > 64'sd2147483647)       acc = 64'sd2147483647;
    else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    if (relu && acc < 0) acc = 0;
    return wordT'(acc);
  endfunction

  function automatic int argOf(input wordT r [OUT_N]);
    int idx = 0;
    for (int n = 1; n < OUT_N; n++) if (r[n] > r[idx]) idx = n;
    return idx;
  endfunction

  task automatic setAll(input int k, input wordT inVal, input wordT wVal, input wordT bVal);
    for (int n = 0; n < OUT_N; n++) begin
      v[k].b[n] = bVal;
      for (int i = 0; i < IN_N; i++) begin
        v[k].w[n][i] = wVal;
        v[k].in[i]   = inVal;
      end
    end
  endtask

  task automatic setExp(input int k, input wordT e0, input wordT e1, input wordT e2,
                        input wordT r0, input wordT r1, input wordT r2, input int a, input int ar);
    v[k].exp[0] = e0; v[k].exp[1] = e1; v[k].exp[2] = e2;
    v[k].expRelu[0] = r0; v[k].expRelu[1] = r1; v[k].expRelu[2] = r2;
    v[k].arg = a; v[k].argRelu = ar;
  endtask

  task automatic loadVec(input int k);
    for (int g = 0; g < 2; g++) begin
      for (int l = 0; l < LANES; l++) begin
        int n = g * LANES + l;
        bMem[g][l*DS +: DS] = (n < OUT_N) ? v[k].b[n] : 32'h0BAD_F00D;
        for (int i = 0; i < IN_N; i++)
          wMem[g*IN_N+i][l*DS +: DS] = (n < OUT_N) ? v[k].w[n][i] : 32'h0BAD_F00D;
      end
    end
    for (int i = 0; i < IN_N; i++) inMem[i] = v[k].in[i];
    capCnt[0] = 0; capCnt[1] = 0; doneCnt[0] = 0; doneCnt[1] = 0;
  endtask

  // Pulses start, optionally re-pulses it at cycle extraAt, and counts cycles to done.
  task automatic startAndWait(input int extraAt, output int lat);
    start = 1;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == extraAt);
      if (done0) break;
    end
    start = 0;
  endtask

  task automatic checkWrites(input int k);
    for (int n = 0; n < OUT_N; n++) begin
      check($sformatf("v%0d wrAdr%0d", k, n), capAdr[0][n], 32'(n));
      check($sformatf("v%0d res%0d", k, n), capData[0][n], v[k].exp[n]);
      check($sformatf("v%0d reluRes%0d", k, n), capData[1][n], v[k].expRelu[n]);
    end
    check($sformatf("v%0d wrCount", k), 32'(capCnt[0]), 32'(OUT_N));
    check($sformatf("v%0d reluWrCount", k), 32'(capCnt[1]), 32'(OUT_N));
    check($sformatf("v%0d doneCount", k), 32'(doneCnt[0]), 32'd1);
  endtask

  task automatic runVec(input int k);
    int lat;
    loadVec(k);
    startAndWait(0, lat);
    check($sformatf("v%0d latency", k), 32'(lat), 32'd16);
    check($sformatf("v%0d argmax", k), 32'(amax0), 32'(v[k].arg));
    check($sformatf("v%0d reluArgmax", k), 32'(amax1), 32'(v[k].argRelu));
    @(posedge clk); #1;
    check($sformatf("v%0d donePulse", k), 32'(done0), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkWrites(k);
  endtask

  initial begin
    int lat;
    wordT r [OUT_N];

    setAll(0, 0, ONE, HALF);
    for (int i = 0; i < IN_N; i++) v[0].in[i] = ONE * (i + 1);
    setExp(0, 32'h000A8000, 32'h000A8000, 32'h000A8000,
              32'h000A8000, 32'h000A8000, 32'h000A8000, 0, 0);
    v[1] = v[0];
    for (int i = 0; i < IN_N; i++) v[1].w[2][i] = TWO;
    setExp(1, 32'h000A8000, 32'h000A8000, 32'h00148000,
              32'h000A8000, 32'h000A8000, 32'h00148000, 2, 2);
    v[2] = v[1];
    for (int i = 0; i < IN_N; i++) v[2].w[0][i] = TWO;
    setExp(2, 32'h00148000, 32'h000A8000, 32'h00148000,
              32'h00148000, 32'h000A8000, 32'h00148000, 0, 0);
    setAll(3, 0, 0, 0);
    v[3].in[0] = K30; v[3].w[0][0] = K30; v[3].w[1][0] = -K30; v[3].w[2][0] = ONE;
    setExp(3, 32'h7FFFFFFF, 32'h80000000, 32'h75300000,
              32'h7FFFFFFF, 32'h00000000, 32'h75300000, 0, 0);
    setAll(4, 0, 0, 0);
    v[4].in[0] = 1; v[4].w[0][0] = 32'hFFFF8000; v[4].w[1][0] = HALF; v[4].w[2][0] = 32'hFFFF0000;
    setExp(4, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF,
              32'h00000000, 32'h00000000, 32'h00000000, 1, 0);
    for (int k = 5; k < NVEC; k++) begin
      for (int n = 0; n < OUT_N; n++) begin
        v[k].b[n] = (k >= 8) ? wordT'($urandom) : wordT'($urandom_range(0, 1 << 20)) - (1 << 19);
        for (int i = 0; i < IN_N; i++) begin
          v[k].w[n][i] = (k >= 8) ? wordT'($urandom) : wordT'($urandom_range(0, 1 << 20)) - (1 << 19);
          v[k].in[i]   = (k >= 8) ? wordT'($urandom) : wordT'($urandom_range(0, 1 << 20)) - (1 << 19);
        end
      end
      for (int n = 0; n < OUT_N; n++) r[n] = model(k, n, 0);
      setExp(k, r[0], r[1], r[2], model(k, 0, 1), model(k, 1, 1), model(k, 2, 1), argOf(r), 0);
      for (int n = 0; n < OUT_N; n++) r[n] = model(k, n, 1);
      v[k].argRelu = argOf(r);
    end

    capCnt[0] = 0; capCnt[1] = 0; doneCnt[0] = 0; doneCnt[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset weightAdr", 32'(wAdr0), 0);
    check("reset biasAdr", 32'(bAdr0), 0);
    check("reset inAdr", 32'(iAdr0), 0);
    check("reset outAdr", 32'(oAdr0), 0);
    check("reset outData", oData0, 0);
    check("reset wr", 32'(wr0), 0);
    check("reset done", 32'(done0), 0);
    check("reset argmax", 32'(amax0), 0);
    rst = 0;
    @(posedge clk); #1;

    for (int k = 0; k < NVEC; k++) begin
      runVec(k);
      $display("vector %0d: results %08h %08h %08h argmax %0d", k,
               capData[0][0], capData[0][1], capData[0][2], amax0);
    end

    // Outputs hold their last values once the engine is idle again.
    check("hold outAdr", 32'(oAdr0), 32'd2);
    check("hold weightAdr", 32'(wAdr0), 32'd7);
    check("hold biasAdr", 32'(bAdr0), 32'd1);
    check("hold inAdr", 32'(iAdr0), 32'd3);
    check("hold wr", 32'(wr0), 32'd0);

    // Start during MAC and during DONE must both be ignored.
    loadVec(0);
    startAndWait(4, lat);
    check("busyStart latency", 32'(lat), 32'd16);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (30) @(posedge clk);
    #1;
    checkWrites(0);
    $display("busy start sequence: %0d writes, %0d done pulses", capCnt[0], doneCnt[0]);

    // Reset mid-MAC aborts with no writes or done, then a clean rerun.
    loadVec(0);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    check("abort wr", 32'(wr0), 0);
    check("abort inAdr", 32'(iAdr0), 0);
    check("abort weightAdr", 32'(wAdr0), 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (25) @(posedge clk);
    #1;
    check("abort wrCount", 32'(capCnt[0]), 0);
    check("abort doneCount", 32'(doneCnt[0]), 0);
    $display("abort sequence: %0d writes, %0d done pulses", capCnt[0], doneCnt[0]);
    runVec(0);
    $display("rerun after abort: results %08h %08h %08h", capData[0][0], capData[0][1], capData[0][2]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
